sdspi_bus_arbiter: RTL and testbench
====================================

# sdspi_bus_arbiter

Arbitrates a single SD SPI host between two requesters: the autotest sequencer (port 0) and the SD-SPI unit under test (port 1). It replaces the static `sdspi_ctrl_mux` select with a registered request/grant handshake. Round-robin fairness applies on contention. The owner's command, address and data are multiplexed to the host, and `busy` is returned to both sides.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 32'd50_000_000: maximum grant duration in `clk` cycles. Used only with the timeout feature.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req0`, `req1`  in  1 each  ownership request; held high for the whole transaction.
- `gnt0`, `gnt1`  out  1 each  registered grant.
- `cmd0_*`, `cmd1_*`  in  requester command sets, one per port:
  - `r_block`, `r_byte`, `r_multi_block`, `w_block`, `w_byte`, `spi_rst`: 1 each.
  - `block_addr`: 32.
  - `data_in`: 8.
- `busy0`, `busy1`  out  1 each  per-requester busy view.
- `data_out0`, `data_out1`  out  8 each  per-requester copy of the host read data.
- `spi_*`  out  host command set, same fields and widths as `cmdN_*`.
- `spi_busy`  in  1  host busy.
- `spi_data_out`  in  8  host read data.
- `timeout`  out  2  sticky timeout flags, bit N for requester N.
- `owner`  out  2  debug: {valid, id}.

## Operation
- States: IDLE, OWN0, OWN1, DRAIN.
- **IDLE**
  - Only `req0` high: go to OWN0.
  - Only `req1` high: go to OWN1.
  - Both high: grant the requester that is not `last`.
  - `last` is a 1-bit pointer updated on every grant. Reset value 1, so port 0 wins the first tie.
- **OWNn**
  - `gntN`=1.
  - `spi_*` = `cmdN_*`.
  - `busyN` = `spi_busy`.
  - The other port sees `busy`=1 and its `gnt`=0.
  - `reqN` low: go to DRAIN.
- **DRAIN**
  - All `spi_*` commands are 0.
  - Address is 0; `data_in` is 8'hFF.
  - Leave for IDLE on the first cycle with `spi_busy`=0.
  - Both `busy` outputs read 1.
- **No owner (IDLE, DRAIN)**
  - Command strobes and `spi_rst` are 0.
  - `spi_block_addr` is 0; `spi_data_in` is 8'hFF.
- **Data paths**
  - `data_outN` always mirrors `spi_data_out`.
- **Simultaneous events**
  - A request arriving in DRAIN waits for IDLE.
  - A request re-asserted in the same cycle the other side drops still passes through DRAIN; there is no back-to-back grant.
- **Reset mid-transaction**
  - The grant drops next cycle and the FSM goes to IDLE.
  - No drain wait: the host is expected to be reset alongside.
- Requesters must not assert command strobes before seeing `gnt`.

## Timing
- Reset values:
  - FSM state IDLE.
  - `gnt0`/`gnt1`=0, `owner`=2'b00, `timeout`=2'b00, `last`=1.
  - `busy0`/`busy1`=1, all `spi_*` strobes 0.
- Grant latency:
  - Request sampled high in IDLE at edge k gives `gnt` high after edge k+1.
  - Command mux follows the registered state combinationally, with zero added latency.
- Release latency:
  - `req` low at edge k gives `gnt` low after edge k+1.
  - Earliest regrant is 2 cycles after DRAIN entry with `spi_busy`=0.

## Configuration
- Macro: `SDSPI_ARB_TIMEOUT_EN`.
- **Defined:**
  - A 32-bit counter clears on grant and increments each cycle in OWNn.
  - At `TIMEOUT_CYCLES`-1 the FSM forces DRAIN, sets `timeout[N]` and locks out port N.
  - The lockout clears when `reqN` is seen low.
  - `timeout` clears only on `rst`.
- **Undefined:**
  - No counter and no lockout.
  - `timeout` tied to 0.
  - Ownership is unbounded.

## Test plan
- Reset, then `req0`=1 only: `gnt0`=1 two edges later, `spi_block_addr` follows `cmd0_block_addr`=32'h00100000, `busy1`=1.
- `req0` and `req1` rise together from reset: port 0 granted. After release and DRAIN, both high again: port 1 granted.
- Port 1 owns, drops `req1` while `spi_busy`=1 for 10 cycles: state stays DRAIN for 10 cycles with all strobes 0. IDLE is reached on the first `spi_busy`=0 cycle.
- `rst` pulsed while OWN1 with `spi_r_block`=1: next cycle `gnt1`=0, `spi_r_block`=0, `owner`=0.
- With `SDSPI_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100, port 0 holds `req0`:
  - `gnt0` falls after 100 granted cycles and `timeout`=2'b01.
  - No regrant to port 0 until `req0` toggles low; port 1's pending request is granted meanwhile.
- Without the macro, same stimulus for 10000 cycles: `gnt0` stays 1 and `timeout`=0.

Source files
------------

// File: rtl/sdspi_bus_arbiter.sv
// sdspi_bus_arbiter
//
// Purpose:
//   Shares one SD SPI host between two requesters. Port 0 is the autotest
//   sequencer and port 1 is the SD-SPI unit under test. Access is granted
//   through a registered request/grant handshake, and ties are broken
//   round-robin. The owner's command set is muxed onto the host. The
//   arbiter leaves a DRAIN state only once the host reports idle.
//
// Optional feature (macro SDSPI_ARB_TIMEOUT_EN):
//   When the macro is defined, a grant is bounded to TIMEOUT_CYCLES cycles.
//   A requester that overruns is forced off and locked out until it drops
//   its request. Its sticky timeout bit is also set.
//   When the macro is undefined, ownership is unbounded and timeout reads 0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req0/req1           ownership requests, held for the whole transaction
//   gnt0/gnt1           registered grants
//   cmd0_*/cmd1_*       per-requester command sets (strobes, address, data)
//   busy0/busy1         per-requester busy view (1 unless owning)
//   data_out0/1         copies of the host read data
//   spi_*               command set driven to the host
//   spi_busy            host busy
//   spi_data_out        host read data
//   timeout             sticky per-requester timeout flags
//   owner               debug {valid, id}

module sdspi_bus_arbiter #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  output logic        gnt0,
  output logic        gnt1,
  input  logic        cmd0_r_block,
  input  logic        cmd0_r_byte,
  input  logic        cmd0_r_multi_block,
  input  logic        cmd0_w_block,
  input  logic        cmd0_w_byte,
  input  logic        cmd0_spi_rst,
  input  logic [31:0] cmd0_block_addr,
  input  logic [7:0]  cmd0_data_in,
  input  logic        cmd1_r_block,
  input  logic        cmd1_r_byte,
  input  logic        cmd1_r_multi_block,
  input  logic        cmd1_w_block,
  input  logic        cmd1_w_byte,
  input  logic        cmd1_spi_rst,
  input  logic [31:0] cmd1_block_addr,
  input  logic [7:0]  cmd1_data_in,
  output logic        busy0,
  output logic        busy1,
  output logic [7:0]  data_out0,
  output logic [7:0]  data_out1,
  output logic        spi_r_block,
  output logic        spi_r_byte,
  output logic        spi_r_multi_block,
  output logic        spi_w_block,
  output logic        spi_w_byte,
  output logic        spi_spi_rst,
  output logic [31:0] spi_block_addr,
  output logic [7:0]  spi_data_in,
  input  logic        spi_busy,
  input  logic [7:0]  spi_data_out,
  output logic [1:0]  timeout,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN0  = 2'd1,
    ST_OWN1  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  req_ok;

`ifdef SDSPI_ARB_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  lock_q, lock_d;
  logic [1:0]  timeout_q, timeout_d;
  logic        expire;

  // A locked-out port is invisible to arbitration until it drops its request.
  assign req_ok = {req1 & ~lock_q[1], req0 & ~lock_q[0]};
  assign expire = (cnt_q == (TIMEOUT_CYCLES - 32'd1));
  assign timeout = timeout_q;

  // The grant-duration counter runs only while someone owns the host. It
  // returns to zero in IDLE/DRAIN, so every new grant starts from 0.
  always_comb begin
    cnt_d     = 32'd0;
    lock_d    = lock_q;
    timeout_d = timeout_q;
    if ((state_q == ST_OWN0) || (state_q == ST_OWN1)) begin
      cnt_d = cnt_q + 32'd1;
    end
    if (!req0) lock_d[0] = 1'b0;
    if (!req1) lock_d[1] = 1'b0;
    if ((state_q == ST_OWN0) && req0 && expire) begin
      lock_d[0]    = 1'b1;
      timeout_d[0] = 1'b1;
    end
    if ((state_q == ST_OWN1) && req1 && expire) begin
      lock_d[1]    = 1'b1;
      timeout_d[1] = 1'b1;
    end
  end
`else
  assign req_ok  = {req1, req0};
  assign timeout = 2'b00;
`endif

  // Next-state logic. On a tie, the port that did not win last time gets
  // the grant. last_q resets to 1, so port 0 wins the first tie.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (req_ok[0] && (!req_ok[1] || last_q)) begin
          state_d = ST_OWN0;
          last_d  = 1'b0;
        end else if (req_ok[1]) begin
          state_d = ST_OWN1;
          last_d  = 1'b1;
        end
      end
      ST_OWN0: begin
        if (!req0) state_d = ST_DRAIN;
`ifdef SDSPI_ARB_TIMEOUT_EN
        else if (expire) state_d = ST_DRAIN;
`endif
      end
      ST_OWN1: begin
        if (!req1) state_d = ST_DRAIN;
`ifdef SDSPI_ARB_TIMEOUT_EN
        else if (expire) state_d = ST_DRAIN;
`endif
      end
      default: begin
        if (!spi_busy) state_d = ST_IDLE;
      end
    endcase
  end

  // Grants and owner are registered from the current state. They therefore
  // rise one edge after the state enters OWNn, so the command path is
  // already switched before a requester can see its grant.
  always_comb begin
    gnt0_d  = (state_q == ST_OWN0);
    gnt1_d  = (state_q == ST_OWN1);
    owner_d = 2'b00;
    if (state_q == ST_OWN0) owner_d = 2'b10;
    if (state_q == ST_OWN1) owner_d = 2'b11;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      owner_q <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      owner_q <= owner_d;
    end
  end

`ifdef SDSPI_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= 32'd0;
      lock_q    <= 2'b00;
      timeout_q <= 2'b00;
    end else begin
      cnt_q     <= cnt_d;
      lock_q    <= lock_d;
      timeout_q <= timeout_d;
    end
  end
`endif

  // Host command mux. With no owner, the bus idles with strobes low,
  // address 0 and data_in 8'hFF. A non-owner always sees busy.
  always_comb begin
    spi_r_block       = 1'b0;
    spi_r_byte        = 1'b0;
    spi_r_multi_block = 1'b0;
    spi_w_block       = 1'b0;
    spi_w_byte        = 1'b0;
    spi_spi_rst       = 1'b0;
    spi_block_addr    = 32'd0;
    spi_data_in       = 8'hFF;
    busy0             = 1'b1;
    busy1             = 1'b1;
    case (state_q)
      ST_OWN0: begin
        spi_r_block       = cmd0_r_block;
        spi_r_byte        = cmd0_r_byte;
        spi_r_multi_block = cmd0_r_multi_block;
        spi_w_block       = cmd0_w_block;
        spi_w_byte        = cmd0_w_byte;
        spi_spi_rst       = cmd0_spi_rst;
        spi_block_addr    = cmd0_block_addr;
        spi_data_in       = cmd0_data_in;
        busy0             = spi_busy;
      end
      ST_OWN1: begin
        spi_r_block       = cmd1_r_block;
        spi_r_byte        = cmd1_r_byte;
        spi_r_multi_block = cmd1_r_multi_block;
        spi_w_block       = cmd1_w_block;
        spi_w_byte        = cmd1_w_byte;
        spi_spi_rst       = cmd1_spi_rst;
        spi_block_addr    = cmd1_block_addr;
        spi_data_in       = cmd1_data_in;
        busy1             = spi_busy;
      end
      default: begin
      end
    endcase
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign owner     = owner_q;
  assign data_out0 = spi_data_out;
  assign data_out1 = spi_data_out;

endmodule

// File: tb/tb_sdspi_bus_arbiter.sv
// Testbench for sdspi_bus_arbiter: reset state, grant/release latency,
// round-robin ties, mux contents per owner, drain behaviour, reset
// mid-transaction and grant timeout (SDSPI_ARB_TIMEOUT_EN) or unbounded
// ownership (default build).

module tb_sdspi_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic        gnt0, gnt1;
  logic [5:0]  s0, s1;
  logic [31:0] a0, a1;
  logic [7:0]  d0, d1;
  logic        busy0, busy1;
  logic [7:0]  data_out0, data_out1;
  logic        o_rb, o_rby, o_rmb, o_wb, o_wby, o_rst;
  logic [31:0] spi_a;
  logic [7:0]  spi_d;
  logic        spi_busy;
  logic [7:0]  spi_data_out;
  logic [1:0]  timeout, owner;
  logic [5:0]  spi_s;

  int total = 0;
  int bad   = 0;

  // Strobe packing used everywhere: {r_block, r_byte, r_multi_block, w_block, w_byte, spi_rst}
  assign spi_s = {o_rb, o_rby, o_rmb, o_wb, o_wby, o_rst};

  sdspi_bus_arbiter #(.TIMEOUT_CYCLES(32'd100)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .cmd0_r_block(s0[5]), .cmd0_r_byte(s0[4]), .cmd0_r_multi_block(s0[3]),
    .cmd0_w_block(s0[2]), .cmd0_w_byte(s0[1]), .cmd0_spi_rst(s0[0]),
    .cmd0_block_addr(a0), .cmd0_data_in(d0),
    .cmd1_r_block(s1[5]), .cmd1_r_byte(s1[4]), .cmd1_r_multi_block(s1[3]),
    .cmd1_w_block(s1[2]), .cmd1_w_byte(s1[1]), .cmd1_spi_rst(s1[0]),
    .cmd1_block_addr(a1), .cmd1_data_in(d1),
    .busy0(busy0), .busy1(busy1), .data_out0(data_out0), .data_out1(data_out1),
    .spi_r_block(o_rb), .spi_r_byte(o_rby), .spi_r_multi_block(o_rmb),
    .spi_w_block(o_wb), .spi_w_byte(o_wby), .spi_spi_rst(o_rst),
    .spi_block_addr(spi_a), .spi_data_in(spi_d),
    .spi_busy(spi_busy), .spi_data_out(spi_data_out),
    .timeout(timeout), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [5:0]  s0;
    logic [31:0] a0;
    logic [7:0]  d0;
    logic [5:0]  s1;
    logic [31:0] a1;
    logic [7:0]  d1;
    logic        sbusy;
    logic [7:0]  sdo;
    logic [5:0]  e_s;
    logic [31:0] e_a;
    logic [7:0]  e_d;
    logic        e_b0;
    logic        e_b1;
  } vec_t;

  vec_t vecs[6];
  vec_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits a bounded number of cycles for a grant; expiry shows up as a failed check.
  task automatic wait_gnt(input int port, input string name);
    int n = 0;
    while (((port == 0) ? gnt0 : gnt1) !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(name, 32'((port == 0) ? gnt0 : gnt1), 32'd1);
  endtask

  // Releases everything, lets the arbiter settle in IDLE, then requests one port.
  task automatic acquire(input int port);
    req0 = 1'b0;
    req1 = 1'b0;
    spi_busy = 1'b0;
    repeat (3) tick();
    if (port == 0) req0 = 1'b1;
    else           req1 = 1'b1;
    repeat (2) tick();
    check((port == 0) ? "acq_gnt0" : "acq_gnt1",
          32'((port == 0) ? gnt0 : gnt1), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    vec_t e;

    vecs[0] = '{0, 6'b100000, 32'h00100000, 8'h5A, 6'b010101, 32'hDEADBEEF, 8'h11, 1'b0, 8'hC3,
                6'b100000, 32'h00100000, 8'h5A, 1'b0, 1'b1};
    vecs[1] = '{0, 6'b000011, 32'hFFFFFFFF, 8'h00, 6'b111111, 32'h00000000, 8'hFF, 1'b1, 8'h00,
                6'b000011, 32'hFFFFFFFF, 8'h00, 1'b1, 1'b1};
    vecs[2] = '{0, 6'b001000, 32'h12345678, 8'hA5, 6'b000000, 32'h0000FFFF, 8'h00, 1'b0, 8'hFF,
                6'b001000, 32'h12345678, 8'hA5, 1'b0, 1'b1};
    vecs[3] = '{1, 6'b111111, 32'hAAAAAAAA, 8'hAA, 6'b010000, 32'h00000200, 8'h3C, 1'b0, 8'h81,
                6'b010000, 32'h00000200, 8'h3C, 1'b1, 1'b0};
    vecs[4] = '{1, 6'b000000, 32'h00000000, 8'h00, 6'b000100, 32'h80000001, 8'hFE, 1'b1, 8'h7E,
                6'b000100, 32'h80000001, 8'hFE, 1'b1, 1'b1};
    vecs[5] = '{1, 6'b100001, 32'h55555555, 8'h12, 6'b000001, 32'h00000000, 8'hFF, 1'b0, 8'h00,
                6'b000001, 32'h00000000, 8'hFF, 1'b1, 1'b0};

    req0 = 1'b0; req1 = 1'b0;
    s0 = '0; s1 = '0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    spi_busy = 1'b0; spi_data_out = 8'h00;

    // Reset values
    do_reset();
    check("rst_gnt0", 32'(gnt0), 32'd0);
    check("rst_gnt1", 32'(gnt1), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_busy", 32'({busy0, busy1}), 32'h3);
    check("rst_strobes", 32'(spi_s), 32'd0);
    check("rst_addr", spi_a, 32'd0);
    check("rst_din", 32'(spi_d), 32'hFF);

    // Single request: command mux switches one edge ahead of the grant
    a0 = 32'h00100000;
    req0 = 1'b1;
    tick();
    check("lat_gnt0_early", 32'(gnt0), 32'd0);
    check("lat_addr_early", spi_a, 32'h00100000);
    tick();
    check("lat_gnt0", 32'(gnt0), 32'd1);
    check("lat_addr", spi_a, 32'h00100000);
    check("lat_busy1", 32'(busy1), 32'd1);
    check("lat_owner", 32'(owner), 32'h2);
    // Release: gnt stays one edge, DRAIN idles the bus immediately
    req0 = 1'b0;
    tick();
    check("rel_gnt0_hold", 32'(gnt0), 32'd1);
    check("rel_addr_drain", spi_a, 32'd0);
    tick();
    check("rel_gnt0", 32'(gnt0), 32'd0);

    // Table-driven mux vectors through a scoreboard queue
    for (int i = 0; i < 6; i++) begin
      if (i == 0 || vecs[i].port != vecs[i-1].port) acquire(vecs[i].port);
      s0 = vecs[i].s0; a0 = vecs[i].a0; d0 = vecs[i].d0;
      s1 = vecs[i].s1; a1 = vecs[i].a1; d1 = vecs[i].d1;
      spi_busy = vecs[i].sbusy; spi_data_out = vecs[i].sdo;
      sb.push_back(vecs[i]);
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("v%0d_strobes", i), 32'(spi_s), 32'(e.e_s));
      check($sformatf("v%0d_addr", i), spi_a, e.e_a);
      check($sformatf("v%0d_din", i), 32'(spi_d), 32'(e.e_d));
      check($sformatf("v%0d_busy", i), 32'({busy0, busy1}), 32'({e.e_b0, e.e_b1}));
      check($sformatf("v%0d_dout", i), 32'({data_out0, data_out1}), 32'({e.sdo, e.sdo}));
      tick();
    end

    // Drain held by spi_busy, with a pending request from port 0
    acquire(1);
    s1 = 6'b111111; a1 = 32'h0BADF00D; d1 = 8'h42;
    s0 = 6'b000010; a0 = 32'hCAFE0000; d0 = 8'h99;
    spi_busy = 1'b1;
    req1 = 1'b0;
    req0 = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("drain_gnt0", 32'(gnt0), 32'd0);
      check("drain_strobes", 32'(spi_s), 32'd0);
      check("drain_addr_din", {spi_a[23:0], spi_d}, 32'h000000FF);
      tick();
    end
    check("drain_gnt1", 32'(gnt1), 32'd0);
    spi_busy = 1'b0;
    tick();
    check("drain_exit_gnt0", 32'(gnt0), 32'd0);
    tick();
    check("regrant_gnt0_early", 32'(gnt0), 32'd0);
    check("regrant_addr", spi_a, 32'hCAFE0000);
    tick();
    check("regrant_gnt0", 32'(gnt0), 32'd1);

    // Reset while port 1 owns with r_block asserted
    acquire(1);
    s1 = 6'b100000;
    #1;
    check("mid_rblock_on", 32'(o_rb), 32'd1);
    rst = 1'b1;
    req1 = 1'b0;
    tick();
    check("mid_gnt1", 32'(gnt1), 32'd0);
    check("mid_rblock", 32'(o_rb), 32'd0);
    check("mid_owner", 32'(owner), 32'd0);
    rst = 1'b0;
    s1 = '0;

    // Round-robin: first tie goes to port 0, next to port 1
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    repeat (2) tick();
    check("tie1_gnt", 32'({gnt0, gnt1}), 32'h2);
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) tick();
    req0 = 1'b1; req1 = 1'b1;
    repeat (2) tick();
    check("tie2_gnt", 32'({gnt0, gnt1}), 32'h1);
    // Port 0 keeps its request while port 1 drops: must go through DRAIN
    req1 = 1'b0;
    tick();
    check("b2b_e1", 32'({gnt0, gnt1}), 32'h1);
    tick();
    check("b2b_e2", 32'({gnt0, gnt1}), 32'h0);
    tick();
    check("b2b_e3", 32'({gnt0, gnt1}), 32'h0);
    tick();
    check("b2b_e4", 32'({gnt0, gnt1}), 32'h2);

`ifdef SDSPI_ARB_TIMEOUT_EN
    // Port 0 overruns its 100-cycle grant
    req0 = 1'b0; req1 = 1'b0;
    do_reset();
    req0 = 1'b1;
    wait_gnt(0, "to_first_gnt0");
    req1 = 1'b1;
    cnt = 1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (gnt0 !== 1'b1) break;
      cnt++;
    end
    check("to_cycles", 32'(cnt), 32'd100);
    check("to_flag", 32'(timeout), 32'h1);
    wait_gnt(1, "to_gnt1_meanwhile");
    check("to_gnt0_off", 32'(gnt0), 32'd0);
    req1 = 1'b0;
    repeat (8) tick();
    check("to_locked", 32'({gnt0, gnt1}), 32'h0);
    req0 = 1'b0;
    tick();
    req0 = 1'b1;
    wait_gnt(0, "to_unlock_gnt0");
    check("to_sticky", 32'(timeout), 32'h1);
`else
    // Ownership is unbounded without the timeout feature
    req0 = 1'b0; req1 = 1'b0;
    do_reset();
    req0 = 1'b1;
    wait_gnt(0, "nt_first_gnt0");
    cnt = 0;
    for (int i = 0; i < 10000; i++) begin
      tick();
      if (gnt0 !== 1'b1) cnt++;
    end
    check("nt_drops", 32'(cnt), 32'd0);
    check("nt_timeout", 32'(timeout), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
